// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Bundles the CPU data-bus signals that run between the sequencer (initiator)
//   and the memory responder.
//
//   Signals:
//     memAddr [15:0]  byte address from the initiator
//     memRe           read request (level)
//     memWe           write request (level)
//     busDIn  [15:0]  write data from the register-file side of the bus
//     busDOut [15:0]  read data from the responder
//     busDOe          busDOut is valid and the responder owns the bus
//     clkHold         the responder is stalling the initiator
//     busErr          access fault (only active when the responder is built
//                     with MEM_RESPONDER_BUSERR_EN; otherwise held at 0)
//
//   Modports:
//     master  the initiator side (drives the request and the write data)
//     slave   the responder side (drives the read data and the handshake)
// -----------------------------------------------------------------------------
interface mem_responder_if;
    logic [15:0] memAddr;
    logic        memRe;
    logic        memWe;
    logic [15:0] busDIn;
    logic [15:0] busDOut;
    logic        busDOe;
    logic        clkHold;
    logic        busErr;

    modport master (
        output memAddr, memRe, memWe, busDIn,
        input  busDOut, busDOe, clkHold, busErr
    );

    modport slave (
        input  memAddr, memRe, memWe, busDIn,
        output busDOut, busDOe, clkHold, busErr
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU's 16-bit data bus. It holds a single-port
//   RAM of 2**ADDR_W 16-bit words and answers level-sensitive read/write
//   requests. Each access stalls the initiator with clkHold for WAIT_STATES
//   cycles; the following cycle is the serving cycle, where read data is
//   driven or write data is committed at its closing edge. With
//   WAIT_STATES == 0 every request is served combinationally in the cycle it
//   appears, and clkHold is never raised.
//
//   Parameters:
//     ADDR_W       word-address width (byte-address span 2**(ADDR_W+1))
//     WAIT_STATES  clkHold cycles per access, 0..15
//
//   Ports:
//     clk   free-running clock, rising edge
//     rst   asynchronous active-low reset
//     bus   mem_responder_if.slave (memAddr, memRe, memWe, busDIn in;
//           busDOut, busDOe, clkHold, busErr out)
//
//   Build option:
//     MEM_RESPONDER_BUSERR_EN  when defined, odd or out-of-range addresses are
//       faults: the access still takes the full hold, then the serving cycle
//       raises busErr, returns 16'h0000 on reads and drops writes. When
//       undefined, busErr is tied 0 and such addresses alias (memAddr[0] and
//       the bits above ADDR_W are ignored).
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    // The IDLE cycle is the first hold cycle and READY is entered from the
    // cnt == 0 WAIT cycle, so WAIT is loaded with N-2 to make N hold cycles.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic                hold;
    logic                serve;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic                req;
    logic                rd_req;
    logic                wr_req;
    logic                fault;
    logic                mem_we;

    assign idx    = bus.memAddr[ADDR_W:1];
    assign req    = bus.memRe | bus.memWe;
    // A simultaneous read and write request is handled purely as a write.
    assign rd_req = bus.memRe & ~bus.memWe;
    assign wr_req = bus.memWe;

`ifdef MEM_RESPONDER_BUSERR_EN
    function automatic logic addr_fault(input logic [15:0] addr);
        logic [31:0] wide;
        wide = 32'(addr);
        return addr[0] || ((wide >> (ADDR_W + 1)) != 32'd0);
    endfunction

    assign fault      = addr_fault(bus.memAddr);
    assign bus.busErr = serve & fault;
`else
    // Address bits outside the word index alias silently in this build.
    logic unused_addr;
    assign unused_addr = ^bus.memAddr;
    assign fault       = 1'b0;
    assign bus.busErr  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        serve     = 1'b0;

        if (WAIT_STATES == 0) begin
            serve = req;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        hold = 1'b1;
                        if (WAIT_STATES == 1) begin
                            state_nxt = ST_READY;
                        end else begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A withdrawn request abandons the access without side effects.
                    if (!req) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        hold = 1'b1;
                        if (cnt == 4'd0) begin
                            state_nxt = ST_READY;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                ST_READY: begin
                    serve     = req;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // Outputs and the write strobe fall to idle the moment reset asserts,
        // without waiting for the state register to be cleared by an edge.
        if (!rst) begin
            hold  = 1'b0;
            serve = 1'b0;
        end
    end

    assign mem_we      = serve & wr_req & ~fault;
    assign bus.clkHold = hold;
    assign bus.busDOe  = serve & rd_req;

    always_comb begin
        bus.busDOut = '0;
        if (serve && rd_req && !fault) begin
            bus.busDOut = mem[idx];
        end
    end

    // RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= bus.busDIn;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed self-checking bench for mem_responder. Three responders share one
//   clock and reset: WAIT_STATES = 0, 1 and 3 (ADDR_W = 10 for all). Inputs
//   change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. Address-fault checks follow MEM_RESPONDER_BUSERR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_responder;

    logic clk;
    logic rst;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mem_responder_if i0 ();
    mem_responder_if i1 ();
    mem_responder_if i3 ();

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(i0.slave));
    mem_responder #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .bus(i1.slave));
    mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(i3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] data);
        case (sel)
            0: begin i0.memRe = rd; i0.memWe = wr; i0.memAddr = addr; i0.busDIn = data; end
            1: begin i1.memRe = rd; i1.memWe = wr; i1.memAddr = addr; i1.busDIn = data; end
            default: begin i3.memRe = rd; i3.memWe = wr; i3.memAddr = addr; i3.busDIn = data; end
        endcase
    endtask

    task automatic sample(input int sel, output logic h, output logic [15:0] d,
                          output logic o, output logic e);
        case (sel)
            0: begin h = i0.clkHold; d = i0.busDOut; o = i0.busDOe; e = i0.busErr; end
            1: begin h = i1.clkHold; d = i1.busDOut; o = i1.busDOe; e = i1.busErr; end
            default: begin h = i3.clkHold; d = i3.busDOut; o = i3.busDOe; e = i3.busErr; end
        endcase
    endtask

    // Runs one access to completion: counts hold cycles, captures the
    // serving-cycle outputs, then releases the request after the serving edge.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          output int holds, output logic [15:0] rdata,
                          output logic oe, output logic err, output logic tmo);
        logic        h, o, e;
        logic [15:0] d;
        drive(sel, rd, wr, addr, data);
        holds = 0; rdata = '0; oe = 1'b0; err = 1'b0; tmo = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            sample(sel, h, d, o, e);
            if (h === 1'b1) begin
                holds++;
                step();
            end else begin
                rdata = d; oe = o; err = e; tmo = 1'b0;
                break;
            end
        end
        step();
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        drive(3, 1'b0, 1'b1, 16'h0004, 16'h0000);
        repeat (2) step();
        @(negedge clk);
        check_cnt++; if (i1.clkHold !== 1'b0) $display("FAIL rst_ws1_hold: got %b want 0", i1.clkHold); else pass_cnt++;
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL rst_ws1_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        check_cnt++; if (i1.busDOut !== 16'h0000) $display("FAIL rst_ws1_dout: got %h want 0000", i1.busDOut); else pass_cnt++;
        check_cnt++; if (i1.busErr !== 1'b0) $display("FAIL rst_ws1_err: got %b want 0", i1.busErr); else pass_cnt++;
        check_cnt++; if (i0.busDOe !== 1'b0) $display("FAIL rst_ws0_oe: got %b want 0", i0.busDOe); else pass_cnt++;
        check_cnt++; if (i0.busDOut !== 16'h0000) $display("FAIL rst_ws0_dout: got %h want 0000", i0.busDOut); else pass_cnt++;
        check_cnt++; if (i3.clkHold !== 1'b0) $display("FAIL rst_ws3_hold: got %b want 0", i3.clkHold); else pass_cnt++;
        step();
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        step();
    endtask

    task automatic test_ws1_write_read();
        drive(1, 1'b0, 1'b1, 16'h0004, 16'hBEEF);
        @(negedge clk);
        check_cnt++; if (i1.clkHold !== 1'b1) $display("FAIL ws1_wr_hold: got %b want 1", i1.clkHold); else pass_cnt++;
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL ws1_wr_hold_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
        @(negedge clk);
        check_cnt++; if (i1.clkHold !== 1'b0) $display("FAIL ws1_wr_ready_hold: got %b want 0", i1.clkHold); else pass_cnt++;
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL ws1_wr_ready_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
        drive(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i1.clkHold !== 1'b1) $display("FAIL ws1_rd_hold: got %b want 1", i1.clkHold); else pass_cnt++;
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL ws1_rd_hold_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
        @(negedge clk);
        check_cnt++; if (i1.clkHold !== 1'b0) $display("FAIL ws1_rd_ready_hold: got %b want 0", i1.clkHold); else pass_cnt++;
        check_cnt++; if (i1.busDOe !== 1'b1) $display("FAIL ws1_rd_ready_oe: got %b want 1", i1.busDOe); else pass_cnt++;
        check_cnt++; if (i1.busDOut !== 16'hBEEF) $display("FAIL ws1_rd_data: got %h want beef", i1.busDOut); else pass_cnt++;
        step();
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL ws1_idle_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
    endtask

    task automatic test_ws3_read();
        int          holds;
        logic [15:0] rdata;
        logic        oe, err, tmo;
        bit   [4:0]  exp_hold = 5'b10111;
        bit   [4:0]  exp_oe   = 5'b01000;
        access(3, 1'b0, 1'b1, 16'h0010, 16'h1234, holds, rdata, oe, err, tmo);
        check_cnt++; if (tmo !== 1'b0 || holds != 3) $display("FAIL ws3_wr_holds: got %0d (timeout %b) want 3", holds, tmo); else pass_cnt++;
        drive(3, 1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_cnt++;
            if (i3.clkHold !== exp_hold[c]) $display("FAIL ws3_rd_hold_c%0d: got %b want %b", c + 1, i3.clkHold, exp_hold[c]);
            else pass_cnt++;
            check_cnt++;
            if (i3.busDOe !== exp_oe[c]) $display("FAIL ws3_rd_oe_c%0d: got %b want %b", c + 1, i3.busDOe, exp_oe[c]);
            else pass_cnt++;
            if (c == 3) begin
                check_cnt++;
                if (i3.busDOut !== 16'h1234) $display("FAIL ws3_rd_data: got %h want 1234", i3.busDOut);
                else pass_cnt++;
            end
            step();
        end
        // The cycle-5 request opened a new access; withdrawing it in WAIT must release the hold.
        drive(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i3.clkHold !== 1'b0) $display("FAIL ws3_abort_hold: got %b want 0", i3.clkHold); else pass_cnt++;
        step();
    endtask

    task automatic test_ws0();
        int          holds;
        logic [15:0] rdata;
        logic        oe, err, tmo;
        access(0, 1'b0, 1'b1, 16'h0000, 16'hA0A0, holds, rdata, oe, err, tmo);
        check_cnt++; if (tmo !== 1'b0 || holds != 0) $display("FAIL ws0_wr_holds: got %0d (timeout %b) want 0", holds, tmo); else pass_cnt++;
        access(0, 1'b0, 1'b1, 16'h0002, 16'hA1A1, holds, rdata, oe, err, tmo);
        drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i0.clkHold !== 1'b0) $display("FAIL ws0_rd0_hold: got %b want 0", i0.clkHold); else pass_cnt++;
        check_cnt++; if (i0.busDOe !== 1'b1) $display("FAIL ws0_rd0_oe: got %b want 1", i0.busDOe); else pass_cnt++;
        check_cnt++; if (i0.busDOut !== 16'hA0A0) $display("FAIL ws0_rd0_data: got %h want a0a0", i0.busDOut); else pass_cnt++;
        step();
        drive(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i0.clkHold !== 1'b0) $display("FAIL ws0_rd2_hold: got %b want 0", i0.clkHold); else pass_cnt++;
        check_cnt++; if (i0.busDOut !== 16'hA1A1) $display("FAIL ws0_rd2_data: got %h want a1a1", i0.busDOut); else pass_cnt++;
        step();
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_cnt++; if (i0.busDOe !== 1'b0) $display("FAIL ws0_idle_oe: got %b want 0", i0.busDOe); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_write();
        int          holds;
        logic [15:0] rdata;
        logic        oe, err, tmo;
        access(3, 1'b0, 1'b1, 16'h0008, 16'h1111, holds, rdata, oe, err, tmo);
        drive(3, 1'b0, 1'b1, 16'h0008, 16'h2222);
        @(negedge clk);
        step();
        #2;
        check_cnt++; if (i3.clkHold !== 1'b1) $display("FAIL rstmid_hold_before: got %b want 1", i3.clkHold); else pass_cnt++;
        rst = 1'b0;
        #1;
        check_cnt++; if (i3.clkHold !== 1'b0) $display("FAIL rstmid_hold_drop: got %b want 0", i3.clkHold); else pass_cnt++;
        repeat (2) step();
        drive(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        step();
        access(3, 1'b1, 1'b0, 16'h0008, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h1111 || oe !== 1'b1) $display("FAIL rstmid_readback: got %h oe %b want 1111 oe 1", rdata, oe); else pass_cnt++;
    endtask

    task automatic test_rd_wr_both();
        int          holds;
        logic [15:0] rdata;
        logic        oe, err, tmo;
        drive(1, 1'b1, 1'b1, 16'h0006, 16'h5A5A);
        @(negedge clk);
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL both_hold_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
        @(negedge clk);
        check_cnt++; if (i1.busDOe !== 1'b0) $display("FAIL both_ready_oe: got %b want 0", i1.busDOe); else pass_cnt++;
        step();
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        access(1, 1'b1, 1'b0, 16'h0006, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h5A5A) $display("FAIL both_readback: got %h want 5a5a", rdata); else pass_cnt++;
        drive(0, 1'b1, 1'b1, 16'h0006, 16'h6B6B);
        @(negedge clk);
        check_cnt++; if (i0.busDOe !== 1'b0) $display("FAIL both_ws0_oe: got %b want 0", i0.busDOe); else pass_cnt++;
        step();
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        access(0, 1'b1, 1'b0, 16'h0006, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h6B6B) $display("FAIL both_ws0_readback: got %h want 6b6b", rdata); else pass_cnt++;
    endtask

    task automatic test_addr();
        int          holds;
        logic [15:0] rdata;
        logic        oe, err, tmo;
`ifdef MEM_RESPONDER_BUSERR_EN
        access(1, 1'b0, 1'b1, 16'h0002, 16'h0202, holds, rdata, oe, err, tmo);
        access(1, 1'b1, 1'b0, 16'h0003, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (err !== 1'b1) $display("FAIL odd_rd_err: got %b want 1", err); else pass_cnt++;
        check_cnt++; if (rdata !== 16'h0000 || oe !== 1'b1) $display("FAIL odd_rd_data: got %h oe %b want 0000 oe 1", rdata, oe); else pass_cnt++;
        check_cnt++; if (holds != 1) $display("FAIL odd_rd_holds: got %0d want 1", holds); else pass_cnt++;
        access(1, 1'b0, 1'b1, 16'h0000, 16'h0C0C, holds, rdata, oe, err, tmo);
        access(1, 1'b0, 1'b1, 16'h0800, 16'hDEAD, holds, rdata, oe, err, tmo);
        check_cnt++; if (err !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", err); else pass_cnt++;
        access(1, 1'b1, 1'b0, 16'h0000, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h0C0C) $display("FAIL oor_wr_dropped: got %h want 0c0c", rdata); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL good_rd_err: got %b want 0", err); else pass_cnt++;
`else
        access(1, 1'b0, 1'b1, 16'h0002, 16'h0202, holds, rdata, oe, err, tmo);
        access(1, 1'b1, 1'b0, 16'h0803, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h0202 || oe !== 1'b1) $display("FAIL alias_rd_data: got %h oe %b want 0202 oe 1", rdata, oe); else pass_cnt++;
        check_cnt++; if (err !== 1'b0) $display("FAIL alias_rd_err: got %b want 0", err); else pass_cnt++;
        access(1, 1'b0, 1'b1, 16'h0805, 16'h0505, holds, rdata, oe, err, tmo);
        access(1, 1'b1, 1'b0, 16'h0004, 16'h0000, holds, rdata, oe, err, tmo);
        check_cnt++; if (rdata !== 16'h0505) $display("FAIL alias_wr_data: got %h want 0505", rdata); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_ws1_write_read();
        test_ws3_read();
        test_ws0();
        test_reset_mid_write();
        test_rd_wr_both();
        test_addr();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
